byte_serial_adder32: RTL and testbench
======================================

# byte_serial_adder32

Multi-cycle 32-bit add/subtract unit that processes its operands one 8-bit slice per clock, LSB slice first, with a registered carry chain between slices. It accepts one operation through a valid/ready request port and returns the sum and four status flags through a valid/ready response port. It is the sequential, area-reduced arithmetic engine behind the 8-bit gate-level slice logic in the RISC-V datapath.

## Interface
- `WIDTH`, default 32: operand width. It must be a multiple of `SLICE_W`.
- `SLICE_W`, default 8: bits processed per cycle.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: the block can accept a request.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `sub` in 1: 0 gives A+B; 1 gives A−B.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `sum` out WIDTH: the result.
- `carry` out 1: carry out of the MSB. For subtract, 1 means no borrow.
- `overflow` out 1: signed overflow.
- `zero` out 1: `sum` == 0.
- `negative` out 1: `sum[WIDTH-1]`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `a` and `b`. If `sub`=1, latch ~`b` instead of `b`.
  - Set the carry register to `sub`, clear the slice counter, and go to RUN.
- **RUN**
  - Each cycle, compute the counter-indexed slice: operand A slice + operand B slice + carry register.
  - Write the slice result into `sum` at the counter position, update the carry register with the slice carry-out, and increment the counter.
  - On the last slice (counter = WIDTH/SLICE_W−1):
    - `carry` = the final carry-out.
    - `overflow` = carry into MSB XOR carry out of MSB.
    - `zero` and `negative` are computed from the complete sum.
    - Go to DONE.
- **DONE**
  - `out_valid`=1. All outputs stay stable until `out_valid`&&`out_ready`.
  - After that handshake, go to IDLE.
- Inputs are sampled only at the accept edge. Later changes to `a`, `b` or `sub` have no effect.
- `in_ready`=0 in RUN and DONE. There is no overlap between operations: a new request cannot be accepted in the same cycle as the output handshake.
- All arithmetic is modulo 2^WIDTH. The slice carry uses a SLICE_W+1-bit add.
- **Reset** (on any cycle, including mid-RUN or in DONE):
  - state=IDLE and the counter is cleared.
  - `sum`=0, `carry`=0, `overflow`=0, `zero`=0, `negative`=0.
  - `out_valid`=0 and `in_ready`=1 from the first cycle after reset.
  - An in-flight operation is discarded.
- If `rst` and `in_valid` are high together, reset wins and the request is not accepted.

## Timing
- Call the accept edge E0.
- Slices are processed on edges E1 through E(WIDTH/SLICE_W). With the defaults, that is E1..E4.
- `out_valid` rises after edge E(WIDTH/SLICE_W), giving a latency of 4 cycles from accept to `out_valid` with the defaults.
- If `out_ready`=1 when `out_valid` rises, the result is consumed on the next edge. `in_ready` rises one cycle later.
- Minimum request-to-request spacing is WIDTH/SLICE_W + 2 cycles, which is 6 cycles with the defaults.
- `in_ready` and `out_valid` are registered state decodes. Neither combinationally depends on `in_valid` or `out_ready`.
- `sum` bits of slices not yet processed are don't-care until `out_valid`=1.

## Structure
- Package `adder_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - Default constants `WIDTH`=32 and `SLICE_W`=8.
  - `NSLICE`=WIDTH/SLICE_W.
  - Counter width `$clog2(NSLICE)`.
- Sub-module `adder_slice`: a combinational SLICE_W-bit adder.
  - Inputs: `x`, `y`, `cin`.
  - Outputs: `s`, `cout`, and `c_msb_in` (carry into the slice MSB, needed for `overflow`).
  - Instantiated once. The top level multiplexes slice operands by the counter.

## Test plan
- **Add across slices:** add 0x000000FF + 0x00000001.
  - Expect `sum`=0x00000100 with `carry`, `overflow`, `zero` and `negative` all 0.
  - `out_valid` rises exactly 4 cycles after accept.
- **Add wrap-around:** add 0xFFFFFFFF + 0x00000001.
  - Expect `sum`=0, `carry`=1, `zero`=1, `overflow`=0.
  - Also add 0x7FFFFFFF + 1 and expect 0x80000000, `overflow`=1, `negative`=1, `carry`=0.
- **Subtract:** subtract 5 − 7.
  - Expect 0xFFFFFFFE, `carry`=0, `negative`=1.
  - Also subtract 0x80000000 − 1 and expect 0x7FFFFFFF, `overflow`=1, `carry`=1.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid`. Outputs must stay stable and `in_ready`=0.
  - Toggle `a` and `b` during RUN. The result must be unaffected.
- **Reset mid-operation:**
  - Assert `rst` on edge E2 of an add. Next cycle expect `out_valid`=0, `in_ready`=1 and all flags 0.
  - Then run 3 + 4 and expect 7.
- **Back-to-back:**
  - Drive `in_valid` constantly high with `out_ready`=1. Accepts must be spaced exactly 6 cycles apart.
  - Compare 1000 random add/sub results against a reference model.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg
// Shared types and default sizing for the byte-serial add/subtract unit.
//   state_t : controller states (IDLE, RUN, DONE)
//   WIDTH   : default operand width
//   SLICE_W : default bits processed per clock
//   NSLICE  : slices per operation with the defaults
//   CNT_W   : slice counter width with the defaults
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH   = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = WIDTH / SLICE_W;
  // A single-slice configuration still needs a 1-bit counter to stay legal.
  localparam int CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

endpackage

// File: rtl/adder_slice.sv
// adder_slice
// Combinational SLICE_W-bit adder used once per clock by the serial adder.
// Ports:
//   x, y     in  SLICE_W : slice operands
//   cin      in  1       : carry into the slice LSB
//   s        out SLICE_W : slice sum
//   cout     out 1       : carry out of the slice MSB
//   c_msb_in out 1       : carry into the slice MSB (for signed overflow)
module adder_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
  assign s     = total[SLICE_W-1:0];
  assign cout  = total[SLICE_W];

  // The MSB sum bit is x^y^carry_in, so the carry into it falls out by XOR.
  assign c_msb_in = x[SLICE_W-1] ^ y[SLICE_W-1] ^ s[SLICE_W-1];

endmodule

// File: rtl/byte_serial_adder32.sv
// byte_serial_adder32
// Multi-cycle add/subtract engine: one SLICE_W-bit slice per clock, LSB first,
// with a registered carry between slices.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : request handshake
//   a, b, sub          : operands and operation select (1 = a - b)
//   out_valid,out_ready: response handshake
//   sum                : result (modulo 2^WIDTH)
//   carry              : carry out of MSB (1 = no borrow when subtracting)
//   overflow           : signed overflow
//   zero, negative     : sum == 0, sum MSB
module byte_serial_adder32
  import adder_pkg::*;
#(
  parameter int WIDTH   = adder_pkg::WIDTH,
  parameter int SLICE_W = adder_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_next;

  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c_msb;
  logic               last;

  assign last    = (cnt == CW'(SLICES - 1));
  assign slice_x = op_a[cnt*SLICE_W +: SLICE_W];
  assign slice_y = op_b[cnt*SLICE_W +: SLICE_W];

  adder_slice #(.SLICE_W(SLICE_W)) u_slice (
    .x        (slice_x),
    .y        (slice_y),
    .cin      (carry_reg),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  // Full sum as it will look after this slice is written, so zero/negative
  // can be taken on the last slice without waiting an extra cycle.
  always_comb begin
    sum_next = sum;
    sum_next[cnt*SLICE_W +: SLICE_W] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction is folded into addition: latch ~b and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a      <= a;
            op_b      <= sub ? ~b : b;
            carry_reg <= sub;
            cnt       <= '0;
          end
        end
        RUN: begin
          sum       <= sum_next;
          carry_reg <= slice_cout;
          cnt       <= cnt + CW'(1);
          if (last) begin
            carry    <= slice_cout;
            overflow <= slice_c_msb ^ slice_cout;
            zero     <= (sum_next == '0);
            negative <= sum_next[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder32.sv
// tb_byte_serial_adder32
// Directed and randomised checks of byte_serial_adder32 with default sizing.
module tb_byte_serial_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  byte_serial_adder32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  // Independent reference: {sum, carry, overflow, zero, negative}.
  function automatic logic [35:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    logic [32:0] t;
    logic [31:0] r;
    logic        c;
    logic        v;
    if (s) begin
      r = x - y;
      c = (x >= y);
      v = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = t[31:0];
      c = t[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end
    return {r, c, v, (r == 32'd0), r[31]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [35:0] exp);
    checkOutput({tag, "_sum"}, sum, exp[35:4]);
    checkOutput({tag, "_carry"}, {31'd0, carry}, {31'd0, exp[3]});
    checkOutput({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp[2]});
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, exp[1]});
    checkOutput({tag, "_negative"}, {31'd0, negative}, {31'd0, exp[0]});
  endtask

  // Present one request and hold it until it is taken at the accept edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; optionally scramble inputs.
  task automatic waitResult(input bit scramble, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (scramble) begin
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [35:0] exp);
    int lat;
    applyStimulus(x, y, s);
    waitResult(1'b0, lat);
    checkOutput({tag, "_latency"}, lat, 32'd4);
    checkFlags(tag, exp);
    consume();
  endtask

  initial begin
    int          lat;
    int          cyc;
    int          last_acc;
    int          results;
    logic [35:0] expq[$];
    logic [35:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkFlags("rst", {32'h0, 4'b0000});

    $display("[TB] directed vectors");
    directed("add_ff_1",     32'h000000FF, 32'h00000001, 1'b0, {32'h00000100, 4'b0000});
    directed("add_wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 4'b1010});
    directed("add_ovf",      32'h7FFFFFFF, 32'h00000001, 1'b0, {32'h80000000, 4'b0101});
    directed("sub_5_7",      32'h00000005, 32'h00000007, 1'b1, {32'hFFFFFFFE, 4'b0001});
    directed("sub_min_1",    32'h80000000, 32'h00000001, 1'b1, {32'h7FFFFFFF, 4'b1100});

    $display("[TB] backpressure with inputs toggled during RUN");
    applyStimulus(32'h12345678, 32'h11111111, 1'b0);
    waitResult(1'b1, lat);
    checkOutput("bp_latency", lat, 32'd4);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_sum", sum, 32'h23456789);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    checkFlags("bp", {32'h23456789, 4'b0000});
    consume();

    $display("[TB] reset in the middle of an operation");
    applyStimulus(32'hFFFFFFF0, 32'h00000020, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkFlags("midrst", {32'h0, 4'b0000});
    repeat (6) begin
      checkOutput("midrst_stays_idle", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    directed("add_3_4", 32'd3, 32'd4, 1'b0, {32'd7, 4'b0000});

    $display("[TB] back-to-back random stream");
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_acc = -1; results = 0;
    while (results < 1000 && cyc < 10000) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          checkFlags("rand", e);
        end
        results++;
      end
      if (in_ready) begin
        if (last_acc >= 0) checkOutput("accept_spacing", cyc - last_acc, 32'd6);
        last_acc = cyc;
        expq.push_back(refModel(a, b, sub));
      end else begin
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (results < 1000) checkOutput("stream_results", results, 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
